audio_reg_sequencer: RTL and testbench

AUDIO_REG_SEQUENCER -- requirements
Module: audio_reg_sequencer

---
 rtl/audio_pkg.sv | 28 ++
 rtl/audio_cmd_fifo.sv | 54 +++++
 rtl/audio_reg_sequencer.sv | 143 ++++++++++++++
 tb/tb_audio_reg_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared state encoding, register indices and command field layout for the audio sequencer
package audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } seq_state_t;

    localparam logic [3:0] REG_FREQ       = 4'd0;
    localparam logic [3:0] REG_PULSEWIDTH = 4'd1;
    localparam logic [3:0] REG_WAVEPARAMS = 4'd2;
    localparam logic [3:0] REG_VOLUME     = 4'd3;

    localparam int CMD_W         = 36;
    localparam int CMD_DELAY_MSB = 35;
    localparam int CMD_DELAY_LSB = 28;
    localparam int CMD_REG_MSB   = 27;
    localparam int CMD_REG_LSB   = 24;
    localparam int CMD_DATA_MSB  = 23;
    localparam int CMD_DATA_LSB  = 0;

    // Word-aligned register address inside the audio bank
    function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [3:0] rg);
        return base + {26'd0, rg, 2'b00};
    endfunction

endpackage

// File: rtl/audio_cmd_fifo.sv
// rtl/audio_cmd_fifo.sv - command FIFO; push/pop arrive pre-qualified, storage is not reset
module audio_cmd_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = CMD_W
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage write; no reset so the array maps onto plain RAM
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; flush returns everything to empty
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/audio_reg_sequencer.sv
// rtl/audio_reg_sequencer.sv - timed audio register write sequencer with CPU-priority arbiter; optional irq via AUDIO_SEQ_IRQ_EN
module audio_reg_sequencer
    import audio_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter int          TICK_DIV  = 16000,
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic                    flush,
    input  logic                    cmd_valid,
    input  logic [35:0]             cmd_data,
    output logic                    cmd_ready,
    input  logic                    cpu_valid,
    input  logic [3:0]              cpu_wstrb,
    input  logic [31:0]             cpu_addr,
    input  logic [31:0]             cpu_wdata,
    output logic                    aud_valid,
    output logic [3:0]              aud_wstrb,
    output logic [31:0]             aud_addr,
    output logic [31:0]             aud_wdata,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fill
`ifdef AUDIO_SEQ_IRQ_EN
    ,
    output logic                    irq
`endif
);

    localparam int FW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TICK_DIV);

    seq_state_t    state, state_next;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [7:0]    delay_cnt;
    logic [3:0]    cur_reg;
    logic [23:0]   cur_data;
    logic [35:0]   head;
    logic          push_fire;
    logic          pop_fire;
    logic          seq_grant;

    assign cmd_ready = (fill < FW'(DEPTH));
    assign push_fire = cmd_valid && cmd_ready && !flush;
    assign pop_fire  = (state == ST_IDLE) && enable && (fill != '0) && !flush;
    assign seq_grant = (state == ST_ISSUE) && !cpu_valid && !flush;
    assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
    assign busy      = (fill != '0) || (state != ST_IDLE);

    audio_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .push   (push_fire),
        .pop    (pop_fire),
        .wdata  (cmd_data),
        .rdata  (head),
        .count  (fill)
    );

    // Free-running tick prescaler
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; flush overrides everything and drops the in-flight command
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (pop_fire) state_next = ST_WAIT;
            ST_WAIT:  if (delay_cnt == 8'd0) state_next = ST_ISSUE;
            ST_ISSUE: if (seq_grant) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (flush) state_next = ST_IDLE;
    end

    // Latch the popped command and count its delay down in ticks
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            delay_cnt <= 8'd0;
            cur_reg   <= 4'd0;
            cur_data  <= 24'd0;
        end else if (pop_fire) begin
            delay_cnt <= head[CMD_DELAY_MSB:CMD_DELAY_LSB];
            cur_reg   <= head[CMD_REG_MSB:CMD_REG_LSB];
            cur_data  <= head[CMD_DATA_MSB:CMD_DATA_LSB];
        end else if ((state == ST_WAIT) && tick && (delay_cnt != 8'd0)) begin
            delay_cnt <= delay_cnt - 8'd1;
        end
    end

    // Registered audio bus; CPU wins, fields hold while idle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aud_valid <= 1'b0;
            aud_wstrb <= 4'd0;
            aud_addr  <= 32'd0;
            aud_wdata <= 32'd0;
        end else begin
            aud_valid <= cpu_valid || seq_grant;
            if (cpu_valid) begin
                aud_wstrb <= cpu_wstrb;
                aud_addr  <= cpu_addr;
                aud_wdata <= cpu_wdata;
            end else if (seq_grant) begin
                aud_wstrb <= 4'b1111;
                aud_addr  <= reg_addr(BASE_ADDR, cur_reg);
                aud_wdata <= {8'h00, cur_data};
            end
        end
    end

`ifdef AUDIO_SEQ_IRQ_EN
    // Pulse when the last queued command is popped and nothing refills it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq <= 1'b0;
        end else begin
            irq <= pop_fire && !push_fire && (fill == FW'(1));
        end
    end
`endif

endmodule

// File: tb/tb_audio_reg_sequencer.sv
// tb/tb_audio_reg_sequencer.sv - self-checking bench for audio_reg_sequencer
module tb_audio_reg_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic        flush;
    logic        cmd_valid;
    logic [35:0] cmd_data;
    logic        cmd_ready;
    logic        cpu_valid;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        aud_valid;
    logic [3:0]  aud_wstrb;
    logic [31:0] aud_addr;
    logic [31:0] aud_wdata;
    logic        busy;
    logic [3:0]  fill;
`ifdef AUDIO_SEQ_IRQ_EN
    logic        irq;
    int          irq_cnt = 0;
`endif

    audio_reg_sequencer #(.DEPTH(8), .TICK_DIV(4), .BASE_ADDR(32'h0300_0000)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .flush     (flush),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .cpu_valid (cpu_valid),
        .cpu_wstrb (cpu_wstrb),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .aud_valid (aud_valid),
        .aud_wstrb (aud_wstrb),
        .aud_addr  (aud_addr),
        .aud_wdata (aud_wdata),
        .busy      (busy),
        .fill      (fill)
`ifdef AUDIO_SEQ_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          cyc;
    } cap_t;

    typedef struct {
        logic [3:0]  rg;
        logic [23:0] data;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;

    cap_t caps[$];
    vec_t vecs[8];
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (aud_valid) caps.push_back('{aud_addr, aud_wdata, aud_wstrb, cyc});
`ifdef AUDIO_SEQ_IRQ_EN
        if (irq) irq_cnt = irq_cnt + 1;
`endif
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [7:0] dly, input logic [3:0] rg, input logic [23:0] data);
        cmd_valid = 1'b1;
        cmd_data  = {dly, rg, data};
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_caps(input int n, input int budget);
        int k;
        k = 0;
        while (caps.size() < n && k < budget) begin
            step(1);
            k++;
        end
    endtask

    initial begin
        int b;
        int push_cyc;
        vecs[0] = '{4'd0,  24'h000001, 32'h0300_0000, 32'h0000_0001};
        vecs[1] = '{4'd1,  24'hABCDEF, 32'h0300_0004, 32'h00AB_CDEF};
        vecs[2] = '{4'd2,  24'h123456, 32'h0300_0008, 32'h0012_3456};
        vecs[3] = '{4'd3,  24'hFFFFFF, 32'h0300_000C, 32'h00FF_FFFF};
        vecs[4] = '{4'd15, 24'h0F0F0F, 32'h0300_003C, 32'h000F_0F0F};
        vecs[5] = '{4'd8,  24'h800000, 32'h0300_0020, 32'h0080_0000};
        vecs[6] = '{4'd4,  24'h000000, 32'h0300_0010, 32'h0000_0000};
        vecs[7] = '{4'd9,  24'h5A5A5A, 32'h0300_0024, 32'h005A_5A5A};

        resetn = 1'b0; enable = 1'b0; flush = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
        cpu_valid = 1'b0; cpu_wstrb = '0; cpu_addr = '0; cpu_wdata = '0;
        step(3);
        check("rst_aud_valid", {31'd0, aud_valid}, 32'd0);
        check("rst_aud_addr", aud_addr, 32'd0);
        check("rst_aud_wdata", aud_wdata, 32'd0);
        check("rst_aud_wstrb", {28'd0, aud_wstrb}, 32'd0);
        check("rst_fill", {28'd0, fill}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
`ifdef AUDIO_SEQ_IRQ_EN
        check("rst_irq", {31'd0, irq}, 32'd0);
`endif
        resetn = 1'b1;
        step(2);

        // Single delayed write: 3 ticks of 4 cycles plus pipeline overhead
        b = caps.size();
        enable = 1'b1;
        push_cyc = cyc;
        push_cmd(8'd3, 4'd0, 24'h001234);
        wait_caps(b + 1, 40);
        check("dly_count", caps.size(), b + 1);
        if (caps.size() > b) begin
            check("dly_addr", caps[b].addr, 32'h0300_0000);
            check("dly_wdata", caps[b].wdata, 32'h0000_1234);
            check("dly_wstrb", {28'd0, caps[b].wstrb}, 32'hF);
            check("dly_latency_ok", {31'd0, (caps[b].cyc - push_cyc >= 8) && (caps[b].cyc - push_cyc <= 16)}, 32'd1);
        end
        step(20);
        check("dly_single", caps.size(), b + 1);

        // Fill the FIFO, refuse a ninth push, then drain in order
        enable = 1'b0;
        b = caps.size();
        for (int i = 0; i < 8; i++) push_cmd(8'd0, vecs[i].rg, vecs[i].data);
        check("full_ready", {31'd0, cmd_ready}, 32'd0);
        check("full_fill", {28'd0, fill}, 32'd8);
        check("full_busy", {31'd0, busy}, 32'd1);
        push_cmd(8'd0, 4'd7, 24'h777777);
        check("ninth_refused", {28'd0, fill}, 32'd8);
        enable = 1'b1;
        wait_caps(b + 8, 100);
        check("drain_count", caps.size(), b + 8);
        for (int i = 0; i < 8; i++) begin
            if (caps.size() > b + i) begin
                check($sformatf("vec%0d_addr", i), caps[b + i].addr, vecs[i].exp_addr);
                check($sformatf("vec%0d_wdata", i), caps[b + i].wdata, vecs[i].exp_wdata);
                check($sformatf("vec%0d_wstrb", i), {28'd0, caps[b + i].wstrb}, 32'hF);
            end
        end
        step(10);
        check("drain_no_extra", caps.size(), b + 8);
        check("drain_fill", {28'd0, fill}, 32'd0);
        check("drain_busy", {31'd0, busy}, 32'd0);

        // CPU priority: five CPU writes first, then the held sequencer write
        enable = 1'b0;
        push_cmd(8'd0, 4'd3, 24'hABCDEF);
        b = caps.size();
        enable = 1'b1;
        cpu_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cpu_addr  = 32'h1000_0000 + 32'(i * 16);
            cpu_wdata = 32'hC0DE_0000 + 32'(i);
            cpu_wstrb = 4'(i + 1);
            step(1);
        end
        cpu_valid = 1'b0;
        wait_caps(b + 6, 20);
        check("arb_count", caps.size(), b + 6);
        if (caps.size() >= b + 6) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("cpu%0d_addr", i), caps[b + i].addr, 32'h1000_0000 + 32'(i * 16));
                check($sformatf("cpu%0d_wdata", i), caps[b + i].wdata, 32'hC0DE_0000 + 32'(i));
                check($sformatf("cpu%0d_wstrb", i), {28'd0, caps[b + i].wstrb}, 32'(i + 1));
            end
            check("arb_seq_addr", caps[b + 5].addr, 32'h0300_000C);
            check("arb_seq_wdata", caps[b + 5].wdata, 32'h00AB_CDEF);
            check("arb_seq_next_cycle", caps[b + 5].cyc, caps[b + 4].cyc + 1);
        end
        step(3);
        check("hold_valid", {31'd0, aud_valid}, 32'd0);
        check("hold_addr", aud_addr, 32'h0300_000C);
        check("hold_wdata", aud_wdata, 32'h00AB_CDEF);

        // Flush during WAIT with three still queued
        enable = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd(8'd5, 4'(i), 24'(i));
        enable = 1'b1;
        step(3);
        check("pre_flush_fill", {28'd0, fill}, 32'd3);
        b = caps.size();
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("flush_fill", {28'd0, fill}, 32'd0);
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_ready", {31'd0, cmd_ready}, 32'd1);
        step(40);
        check("flush_no_write", caps.size(), b);

        // Flush coincident with push drops the pushed entry
        flush = 1'b1;
        push_cmd(8'd0, 4'd1, 24'h111111);
        flush = 1'b0;
        check("flush_push_fill", {28'd0, fill}, 32'd0);
        step(6);
        check("flush_push_no_write", caps.size(), b);

        // Asynchronous reset while the sequencer is held in ISSUE
        enable = 1'b0;
        push_cmd(8'd0, 4'd2, 24'h222222);
        enable = 1'b1;
        cpu_valid = 1'b1;
        cpu_addr = 32'h2000_0000; cpu_wdata = 32'h1; cpu_wstrb = 4'h1;
        step(4);
        check("issue_pre_valid", {31'd0, aud_valid}, 32'd1);
        #3 resetn = 1'b0;
        #1;
        check("areset_valid", {31'd0, aud_valid}, 32'd0);
        check("areset_fill", {28'd0, fill}, 32'd0);
        check("areset_busy", {31'd0, busy}, 32'd0);
        check("areset_addr", aud_addr, 32'd0);
        cpu_valid = 1'b0;
        b = caps.size();
        #2 resetn = 1'b1;
        step(10);
        check("areset_dropped", caps.size(), b);

`ifdef AUDIO_SEQ_IRQ_EN
        // irq pulses only when the second of two commands is popped
        enable = 1'b0;
        push_cmd(8'd0, 4'd0, 24'h0000AA);
        push_cmd(8'd0, 4'd1, 24'h0000BB);
        irq_cnt = 0;
        enable = 1'b1;
        step(2);
        check("irq_not_first_pop", irq_cnt, 0);
        step(15);
        check("irq_once", irq_cnt, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
